// File: rtl/timeout_recovery_ctrl.sv
// Purpose : watchdog-timeout responder; captures the stalled busy source, pulses its reset, escalates to global reset.
// Latency : rst outputs go low 2 cycles after timeout_in is seen; hold spans 1+RST_PULSE_LEN+GUARD_LEN cycles.
// Backpr. : none; timeout_in is ignored outside IDLE, irq is held until status_ack.
// Ports   : clk/rst (sync, active-low); timeout_in, busy0..2, status_ack in;
//           watchdog_hold, rst_src_n[2:0], rst_global_n, timeout_irq, timeout_src[1:0], timeout_cnt out.
module timeout_recovery_ctrl #(
    parameter int RST_PULSE_LEN = 16,
    parameter int GUARD_LEN     = 64,
    parameter int ESC_LIMIT     = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timeout_in,
    input  logic             busy0,
    input  logic             busy1,
    input  logic             busy2,
    input  logic             status_ack,
    output logic             watchdog_hold,
    output logic [2:0]       rst_src_n,
    output logic             rst_global_n,
    output logic             timeout_irq,
    output logic [1:0]       timeout_src,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int ESC_W = $clog2(ESC_LIMIT + 1);
    localparam logic [ESC_W-1:0] ESC_MAX    = ESC_W'(ESC_LIMIT);
    localparam logic [7:0]       PULSE_LAST = 8'(RST_PULSE_LEN - 1);
    localparam logic [7:0]       GUARD_LAST = 8'(GUARD_LEN - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, PULSE, GUARD} state_t;

    state_t           state_q, state_d;
    logic [2:0]       mask_q, mask_d;
    logic [ESC_W-1:0] esc_cnt_q, esc_cnt_d;
    logic             esc_q, esc_d;
    logic [7:0]       timer_q, timer_d;
    logic             hold_q, hold_d;
    logic [2:0]       src_n_q, src_n_d;
    logic             glb_n_q, glb_n_d;
    logic             irq_q, irq_d;
    logic [1:0]       tsrc_q, tsrc_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    logic [2:0]       busy_vec;
    logic [ESC_W-1:0] esc_inc;

    assign busy_vec = {busy2, busy1, busy0};
    assign esc_inc  = (esc_cnt_q == ESC_MAX) ? esc_cnt_q : esc_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        esc_cnt_d = esc_cnt_q;
        esc_d     = esc_q;
        timer_d   = timer_q;
        tsrc_d    = tsrc_q;
        tcnt_d    = tcnt_q;
        irq_d     = irq_q;

        case (state_q)
            IDLE: begin
                if (status_ack) esc_cnt_d = '0;
                if (timeout_in) state_d = CAPTURE;
            end
            CAPTURE: begin
                mask_d = busy_vec;
                if (busy_vec[0])      tsrc_d = 2'd0;
                else if (busy_vec[1]) tsrc_d = 2'd1;
                else if (busy_vec[2]) tsrc_d = 2'd2;
                else                  tsrc_d = 2'd3;
                if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
                esc_cnt_d = esc_inc;
                // Unknown source or too many unacknowledged timeouts: reset everything.
                esc_d   = (busy_vec == 3'b000) || (esc_inc == ESC_MAX);
                timer_d = '0;
                state_d = PULSE;
            end
            PULSE: begin
                if (timer_q == PULSE_LAST) begin
                    timer_d = '0;
                    state_d = GUARD;
                    if (esc_q) esc_cnt_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            GUARD: begin
                if (timer_q == GUARD_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set (first PULSE cycle) has priority over an ack in the same cycle.
        if (state_q == CAPTURE)  irq_d = 1'b1;
        else if (status_ack)     irq_d = 1'b0;

        // Outputs are registered off the next state so they line up with it.
        hold_d  = (state_d != IDLE);
        src_n_d = (state_d == PULSE && !esc_d) ? ~mask_d : 3'b111;
        glb_n_d = !(state_d == PULSE && esc_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            esc_cnt_q <= '0;
            esc_q     <= 1'b0;
            timer_q   <= '0;
            hold_q    <= 1'b0;
            src_n_q   <= 3'b111;
            glb_n_q   <= 1'b1;
            irq_q     <= 1'b0;
            tsrc_q    <= 2'd3;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            esc_cnt_q <= esc_cnt_d;
            esc_q     <= esc_d;
            timer_q   <= timer_d;
            hold_q    <= hold_d;
            src_n_q   <= src_n_d;
            glb_n_q   <= glb_n_d;
            irq_q     <= irq_d;
            tsrc_q    <= tsrc_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign watchdog_hold = hold_q;
    assign rst_src_n     = src_n_q;
    assign rst_global_n  = glb_n_q;
    assign timeout_irq   = irq_q;
    assign timeout_src   = tsrc_q;
    assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_timeout_recovery_ctrl.sv
// Purpose : directed self-checking bench for timeout_recovery_ctrl (default params + a CNT_W=2 short instance).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : not applicable.
module tb_timeout_recovery_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       timeout_in, busy0, busy1, busy2, status_ack;
    logic       watchdog_hold, rst_global_n, timeout_irq;
    logic [2:0] rst_src_n;
    logic [1:0] timeout_src;
    logic [7:0] timeout_cnt;

    logic       tout2, ack2;
    logic       hold2, glb2_n, irq2;
    logic [2:0] src2_n;
    logic [1:0] tsrc2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timeout_recovery_ctrl dut (
        .clk(clk), .rst(rst), .timeout_in(timeout_in),
        .busy0(busy0), .busy1(busy1), .busy2(busy2), .status_ack(status_ack),
        .watchdog_hold(watchdog_hold), .rst_src_n(rst_src_n), .rst_global_n(rst_global_n),
        .timeout_irq(timeout_irq), .timeout_src(timeout_src), .timeout_cnt(timeout_cnt)
    );

    timeout_recovery_ctrl #(.RST_PULSE_LEN(2), .GUARD_LEN(2), .ESC_LIMIT(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .timeout_in(tout2),
        .busy0(1'b0), .busy1(1'b0), .busy2(1'b0), .status_ack(ack2),
        .watchdog_hold(hold2), .rst_src_n(src2_n), .rst_global_n(glb2_n),
        .timeout_irq(irq2), .timeout_src(tsrc2), .timeout_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_idle(input string tag);
        status_ack = 1'b1;
        tick(1);
        status_ack = 1'b0;
        check({tag, "_irq_clr"}, 8'(timeout_irq), 8'd0);
    endtask

    // ack_mode: 0 none, 1 ack during CAPTURE (set must win), 2 ack in GUARD.
    task automatic do_timeout(input string tag, input logic [2:0] busy, input int ack_mode,
                              input logic [2:0] exp_src_n, input logic exp_glb_n,
                              input logic [1:0] exp_src, input logic [7:0] exp_cnt);
        {busy2, busy1, busy0} = busy;
        timeout_in = 1'b1;
        tick(1);
        timeout_in = 1'b0;
        check({tag, "_cap_hold"}, 8'(watchdog_hold), 8'd1);
        check({tag, "_cap_rst"}, 8'({rst_global_n, rst_src_n}), 8'h0f);
        if (ack_mode == 1) status_ack = 1'b1;
        tick(1);
        status_ack = 1'b0;
        check({tag, "_pulse_rst"}, 8'({rst_global_n, rst_src_n}), 8'({exp_glb_n, exp_src_n}));
        check({tag, "_irq"}, 8'(timeout_irq), 8'd1);
        check({tag, "_src"}, 8'(timeout_src), 8'(exp_src));
        check({tag, "_cnt"}, timeout_cnt, exp_cnt);
        tick(15);
        check({tag, "_pulse_last"}, 8'({rst_global_n, rst_src_n}), 8'({exp_glb_n, exp_src_n}));
        tick(1);
        check({tag, "_guard_rst"}, 8'({rst_global_n, rst_src_n}), 8'h0f);
        check({tag, "_guard_hold"}, 8'(watchdog_hold), 8'd1);
        if (ack_mode == 2) begin
            status_ack = 1'b1;
            tick(1);
            status_ack = 1'b0;
            check({tag, "_guard_ack"}, 8'(timeout_irq), 8'd0);
            tick(62);
        end else begin
            tick(63);
        end
        check({tag, "_guard_end"}, 8'(watchdog_hold), 8'd1);
        tick(1);
        check({tag, "_idle_hold"}, 8'(watchdog_hold), 8'd0);
        {busy2, busy1, busy0} = 3'b000;
    endtask

    task automatic pulse_sat;
        tout2 = 1'b1;
        tick(1);
        tout2 = 1'b0;
        tick(8);
    endtask

    initial begin
        rst = 1'b0;
        timeout_in = 1'b0; status_ack = 1'b0;
        busy0 = 1'b0; busy1 = 1'b0; busy2 = 1'b0;
        tout2 = 1'b0; ack2 = 1'b0;
        tick(2);
        check("rst_src_n", 8'(rst_src_n), 8'h07);
        check("rst_glb", 8'(rst_global_n), 8'd1);
        check("rst_hold", 8'(watchdog_hold), 8'd0);
        check("rst_irq", 8'(timeout_irq), 8'd0);
        check("rst_src", 8'(timeout_src), 8'd3);
        check("rst_cnt", timeout_cnt, 8'd0);
        rst = 1'b1;
        tick(1);

        do_timeout("single", 3'b010, 0, 3'b101, 1'b1, 2'd1, 8'd1);
        ack_idle("single");
        do_timeout("multi", 3'b101, 0, 3'b010, 1'b1, 2'd0, 8'd2);
        ack_idle("multi");
        // Escalation: esc_cnt must survive the GUARD ack and the CAPTURE ack.
        do_timeout("esc1", 3'b100, 2, 3'b011, 1'b1, 2'd2, 8'd3);
        do_timeout("esc2", 3'b100, 1, 3'b011, 1'b1, 2'd2, 8'd4);
        do_timeout("esc3", 3'b100, 0, 3'b111, 1'b0, 2'd2, 8'd5);
        do_timeout("unknown", 3'b000, 0, 3'b111, 1'b0, 2'd3, 8'd6);
        ack_idle("esc");
        do_timeout("esc4", 3'b100, 0, 3'b011, 1'b1, 2'd2, 8'd7);

        // Synchronous reset in the middle of a pulse.
        busy1 = 1'b1;
        timeout_in = 1'b1;
        tick(1);
        timeout_in = 1'b0;
        tick(5);
        check("midpulse_low", 8'(rst_src_n), 8'h05);
        rst = 1'b0;
        tick(1);
        check("abort_src_n", 8'(rst_src_n), 8'h07);
        check("abort_glb", 8'(rst_global_n), 8'd1);
        check("abort_hold", 8'(watchdog_hold), 8'd0);
        check("abort_cnt", timeout_cnt, 8'd0);
        rst = 1'b1;
        busy1 = 1'b0;
        tick(2);
        check("abort_idle_hold", 8'(watchdog_hold), 8'd0);

        // Counter saturation on the CNT_W=2 instance.
        pulse_sat();
        pulse_sat();
        check("sat_cnt2", 8'(cnt2), 8'd2);
        pulse_sat();
        pulse_sat();
        pulse_sat();
        check("sat_cnt5", 8'(cnt2), 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timeout_recovery_ctrl.md
# timeout_recovery_ctrl

Responder to the MOPS-Hub timeout watchdog. It reacts to a watchdog timeout event, works out which busy source (0/1/2) was stalled, and drives a fixed-length active-low reset pulse to that subsystem. While recovery runs it gates the watchdog so the timeout cannot re-trigger, then raises a status interrupt with an acknowledge handshake. Repeated unacknowledged timeouts escalate to a global reset.

## Interface
- RST_PULSE_LEN, 16: cycles the source or global reset is held low (1..255).
- GUARD_LEN, 64: post-pulse hold-off cycles (1..255).
- ESC_LIMIT, 3: consecutive unacknowledged timeouts that force a global reset.
- CNT_W, 8: width of the total timeout counter.
- clk  in  1  system clock (40 MHz).
- rst  in  1  reset rst, synchronous, active-low; clock clk.
- timeout_in  in  1  level timeout flag from the watchdog.
- busy0, busy1, busy2  in  1 each  per-source activity lines, the same signals that feed the watchdog enables.
- status_ack  in  1  software/host acknowledge, single-cycle pulse.
- watchdog_hold  out  1  high = gate all watchdog enables low.
- rst_src_n  out  3  active-low per-source reset; bit i resets source i.
- rst_global_n  out  1  active-low global reset.
- timeout_irq  out  1  sticky status interrupt.
- timeout_src  out  2  lowest-index captured source; 3 = none/unknown.
- timeout_cnt  out  CNT_W  total timeouts, saturating.

## Operation
- Reset values: rst_src_n=3'b111, rst_global_n=1, watchdog_hold=0, timeout_irq=0, timeout_src=3, timeout_cnt=0. Internal state: FSM=IDLE, mask=0, esc_cnt=0, timer=0.
- FSM states are IDLE, CAPTURE, PULSE and GUARD.
- **IDLE**
  - If timeout_in=1, go to CAPTURE.
  - timeout_in is ignored in every other state.
- **CAPTURE** (1 cycle)
  - mask <= {busy2,busy1,busy0}.
  - timeout_src <= lowest set index of mask, or 3 if mask=0.
  - timeout_cnt increments, saturating at 2^CNT_W-1.
  - esc_cnt increments, saturating at ESC_LIMIT.
  - Next state is PULSE.
- **PULSE** (exactly RST_PULSE_LEN cycles)
  - Escalation applies when mask=0 or the incremented esc_cnt=ESC_LIMIT. In that case rst_global_n=0, rst_src_n stays 3'b111, and esc_cnt clears at PULSE exit.
  - Otherwise rst_src_n = ~mask, so all busy sources are reset together.
  - timeout_irq is set on the first PULSE cycle.
- **GUARD** (exactly GUARD_LEN cycles)
  - All resets are released.
  - After GUARD_LEN cycles, go to IDLE.
- watchdog_hold=1 in CAPTURE, PULSE and GUARD; 0 in IDLE.
- **Acknowledge**
  - status_ack=1 clears timeout_irq on the next edge, in any state.
  - If a set and an ack land in the same cycle, the set wins.
  - status_ack in IDLE also clears esc_cnt. In other states it does not touch esc_cnt.
- Synchronous rst low, mid-operation: all outputs return to their reset values on that edge, and any pulse is aborted.

## Timing
- timeout_in high seen at edge N: CAPTURE at N+1, first PULSE cycle at N+2.
- Reset outputs are registered: low from edge N+2 through edge N+1+RST_PULSE_LEN.
- watchdog_hold is high from N+1 until the end of GUARD. Total busy time is 1+RST_PULSE_LEN+GUARD_LEN cycles.
- Earliest re-detection is the first IDLE cycle. The watchdog clears within 2 cycles of hold, so any GUARD_LEN of 2 or more prevents a stale retrigger.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single source:** busy1=1, timeout_in pulse -> timeout_src=1, rst_src_n=3'b101 for 16 cycles starting 2 cycles after detect, then 64 guard cycles, irq=1, cnt=1.
- **Multiple sources:** busy0=busy2=1 -> rst_src_n=3'b010, timeout_src=0.
- **Unknown source:** all busy=0 at capture -> rst_global_n=0 for 16 cycles, timeout_src=3.
- **Escalation:** three timeouts on busy2 with no ack -> the first two pulse rst_src_n[2], the third pulses rst_global_n; a fourth timeout after an IDLE ack pulses rst_src_n[2] again.
- **Ack handshake:** status_ack during GUARD -> irq=0 next cycle, esc_cnt not cleared. Ack on the same cycle as the PULSE entry -> irq stays 1.
- **Reset and saturation:** rst low mid-PULSE -> all resets deassert on that edge and FSM is IDLE. With CNT_W=2, five timeouts -> timeout_cnt=3.
